// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding, the default reset PC, and the word-alignment test used on
// committed next-PC values.
package fetch_sequencer_pkg;

  // One request in flight at a time; HALT is terminal until reset.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_DELIVER = 3'd3,
    ST_EXEC    = 3'd4,
    ST_HALT    = 3'd5
  } fetch_state_e;

  // PC loaded whenever reset is asserted.
  localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;

  // Instructions are 32-bit words; anything with nonzero low bits is unusable.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction-fetch sequencer. Holds the architectural PC,
// issues one instruction-memory request at a time, hands the fetched word
// to decode, then waits for writeback to commit the next PC. All outputs
// come straight from registers or from decoding the registered state.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o,
  input  logic              commit_i,
  input  logic [AWIDTH-1:0] next_pc_i,
  output logic              misaligned_o,
  output logic [31:0]       retired_o
);

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [AWIDTH-1:0] pc;
  logic [DWIDTH-1:0] insn;
  logic              misaligned;
  logic [31:0]       retired;

  // Update strobes produced by the FSM decode.
  logic              capture_insn;
  logic              load_pc;
  logic              count_commit;
  logic              set_misaligned;

  // Next-state and register-update decode; every commit/response outside
  // its own state falls through to the defaults and is dropped.
  always_comb begin
    state_next     = state;
    capture_insn   = 1'b0;
    load_pc        = 1'b0;
    count_commit   = 1'b0;
    set_misaligned = 1'b0;
    unique case (state)
      ST_IDLE: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        if (imem_req_ready_i) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid_i) begin
          capture_insn = 1'b1;
          state_next   = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (insn_ready_i) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (commit_i) begin
          count_commit = 1'b1;
          if (is_word_aligned(next_pc_i[1:0])) begin
            load_pc    = 1'b1;
            state_next = ST_REQ;
          end else begin
            set_misaligned = 1'b1;
            state_next     = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // PC register: taken verbatim from writeback, no arithmetic here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= BASEADDR;
    end else if (load_pc) begin
      pc <= next_pc_i;
    end
  end

  // Instruction register: captured once per fetch, held through DELIVER.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      insn <= '0;
    end else if (capture_insn) begin
      insn <= imem_rsp_data_i;
    end
  end

  // Sticky misalignment flag; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned <= 1'b0;
    end else if (set_misaligned) begin
      misaligned <= 1'b1;
    end
  end

  // Retired-commit counter, wrapping naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (count_commit) begin
      retired <= retired + 32'd1;
    end
  end

  assign imem_req_valid_o = (state == ST_REQ);
  assign imem_req_addr_o  = pc;
  assign insn_valid_o     = (state == ST_DELIVER);
  assign insn_o           = insn;
  assign pc_o             = pc;
  assign misaligned_o     = misaligned;
  assign retired_o        = retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: inputs change and outputs are
// checked on the falling clock edge, away from the active rising edge.
`timescale 1ns/1ps
module tb_fetch_sequencer;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] insn_o;
  logic [31:0] pc_o;
  logic        commit_i;
  logic [31:0] next_pc_i;
  logic        misaligned_o;
  logic [31:0] retired_o;

  int tests = 0;
  int fails = 0;

  fetch_sequencer #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .insn_valid_o     (insn_valid_o),
    .insn_ready_i     (insn_ready_i),
    .insn_o           (insn_o),
    .pc_o             (pc_o),
    .commit_i         (commit_i),
    .next_pc_i        (next_pc_i),
    .misaligned_o     (misaligned_o),
    .retired_o        (retired_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one full fetch from REQ to EXEC (stimulus only).
  task automatic fetch_to_exec(input logic [31:0] data);
    imem_req_ready_i = 1'b1; tick(); imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = data; tick(); imem_rsp_valid_i = 1'b0;
    insn_ready_i = 1'b1; tick(); insn_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
    insn_ready_i = 1'b0; commit_i = 1'b0; next_pc_i = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({imem_req_valid_o, insn_valid_o, misaligned_o} !== 3'b000 || retired_o !== 32'd0 ||
          imem_req_addr_o !== BASE || pc_o !== BASE || insn_o !== 32'd0) begin
        fails++;
        $display("FAIL reset_values cyc%0d: rv=%b iv=%b mis=%b ret=%h addr=%h pc=%h insn=%h (want 0 0 0 0 %h %h 0)",
                 i, imem_req_valid_o, insn_valid_o, misaligned_o, retired_o, imem_req_addr_o, pc_o, insn_o, BASE, BASE);
      end
    end
    reset = 1'b1;
    tick();
    tests++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== BASE) begin
      fails++;
      $display("FAIL start_req: valid=%b addr=%h (want 1 %h)", imem_req_valid_o, imem_req_addr_o, BASE);
    end
  endtask

  task automatic test_backpressure();
    imem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== BASE) begin
        fails++;
        $display("FAIL req_hold cyc%0d: valid=%b addr=%h (want 1 %h)", i, imem_req_valid_o, imem_req_addr_o, BASE);
      end
    end
    imem_req_ready_i = 1'b1; tick(); imem_req_ready_i = 1'b0;
    tests++;
    if (imem_req_valid_o !== 1'b0 || insn_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL req_accept: valid=%b insn_valid=%b (want 0 0)", imem_req_valid_o, insn_valid_o);
    end
  endtask

  task automatic test_fetch_deliver();
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0013; tick();
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (insn_valid_o !== 1'b1 || insn_o !== 32'h0000_0013 || pc_o !== BASE) begin
        fails++;
        $display("FAIL deliver_hold cyc%0d: iv=%b insn=%h pc=%h (want 1 00000013 %h)", i, insn_valid_o, insn_o, pc_o, BASE);
      end
      if (i < 2) tick();
    end
    // Handshake and commit together: only the handshake counts.
    insn_ready_i = 1'b1; commit_i = 1'b1; next_pc_i = 32'h0200_0000; tick();
    insn_ready_i = 1'b0; commit_i = 1'b0;
    tests++;
    if (insn_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0 || retired_o !== 32'd0) begin
      fails++;
      $display("FAIL deliver_commit_overlap: iv=%b rv=%b ret=%0d (want 0 0 0)", insn_valid_o, imem_req_valid_o, retired_o);
    end
  endtask

  task automatic test_commit();
    commit_i = 1'b1; next_pc_i = 32'h0100_0004; tick(); commit_i = 1'b0;
    tests++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0100_0004 || retired_o !== 32'd1) begin
      fails++;
      $display("FAIL commit_pc4: rv=%b addr=%h ret=%0d (want 1 01000004 1)", imem_req_valid_o, imem_req_addr_o, retired_o);
    end
    imem_req_ready_i = 1'b1; tick(); imem_req_ready_i = 1'b0;
    commit_i = 1'b1; next_pc_i = 32'h1234_5678; tick(); commit_i = 1'b0;
    tests++;
    if (retired_o !== 32'd1 || imem_req_valid_o !== 1'b0 || insn_valid_o !== 1'b0 || pc_o !== 32'h0100_0004) begin
      fails++;
      $display("FAIL commit_in_wait: ret=%0d rv=%b iv=%b pc=%h (want 1 0 0 01000004)", retired_o, imem_req_valid_o, insn_valid_o, pc_o);
    end
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0040_0093; tick(); imem_rsp_valid_i = 1'b0;
    tests++;
    if (insn_valid_o !== 1'b1 || insn_o !== 32'h0040_0093 || pc_o !== 32'h0100_0004) begin
      fails++;
      $display("FAIL second_fetch: iv=%b insn=%h pc=%h (want 1 00400093 01000004)", insn_valid_o, insn_o, pc_o);
    end
    insn_ready_i = 1'b1; tick(); insn_ready_i = 1'b0;
    commit_i = 1'b1; next_pc_i = 32'hDEAD_BEEC; tick(); commit_i = 1'b0;
    tests++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'hDEAD_BEEC || retired_o !== 32'd2) begin
      fails++;
      $display("FAIL commit_branch: rv=%b addr=%h ret=%0d (want 1 deadbeec 2)", imem_req_valid_o, imem_req_addr_o, retired_o);
    end
    // Response in the acceptance cycle is dropped.
    imem_req_ready_i = 1'b1; imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0BAD; tick();
    imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0;
    tests++;
    if (insn_valid_o !== 1'b0 || imem_req_valid_o !== 1'b0) begin
      fails++;
      $display("FAIL rsp_in_accept_cycle: iv=%b rv=%b (want 0 0)", insn_valid_o, imem_req_valid_o);
    end
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0000_0013; tick(); imem_rsp_valid_i = 1'b0;
    tests++;
    if (insn_valid_o !== 1'b1 || insn_o !== 32'h0000_0013 || pc_o !== 32'hDEAD_BEEC) begin
      fails++;
      $display("FAIL fetch_after_branch: iv=%b insn=%h pc=%h (want 1 00000013 deadbeec)", insn_valid_o, insn_o, pc_o);
    end
    insn_ready_i = 1'b1; tick(); insn_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    commit_i = 1'b1; next_pc_i = 32'hFFFF_FFFC; tick(); commit_i = 1'b0;
    tests++;
    if (imem_req_addr_o !== 32'hFFFF_FFFC || retired_o !== 32'd3) begin
      fails++;
      $display("FAIL pc_top: addr=%h ret=%0d (want fffffffc 3)", imem_req_addr_o, retired_o);
    end
    fetch_to_exec(32'h0000_0013);
    commit_i = 1'b1; next_pc_i = 32'h0000_0000; tick(); commit_i = 1'b0;
    tests++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== 32'h0 || misaligned_o !== 1'b0 || retired_o !== 32'd4) begin
      fails++;
      $display("FAIL pc_wrap: rv=%b addr=%h mis=%b ret=%0d (want 1 0 0 4)", imem_req_valid_o, imem_req_addr_o, misaligned_o, retired_o);
    end
    fetch_to_exec(32'h0000_0013);
  endtask

  task automatic test_misaligned();
    commit_i = 1'b1; next_pc_i = 32'hDEAD_BEEF; tick(); commit_i = 1'b0;
    tests++;
    if (misaligned_o !== 1'b1 || imem_req_valid_o !== 1'b0 || retired_o !== 32'd5 || imem_req_addr_o !== 32'h0) begin
      fails++;
      $display("FAIL misaligned: mis=%b rv=%b ret=%0d addr=%h (want 1 0 5 0)", misaligned_o, imem_req_valid_o, retired_o, imem_req_addr_o);
    end
    for (int i = 0; i < 3; i++) begin
      imem_rsp_valid_i = 1'b1; commit_i = 1'b1; insn_ready_i = 1'b1; imem_req_ready_i = 1'b1;
      next_pc_i = 32'h0100_0000; tick();
      tests++;
      if (misaligned_o !== 1'b1 || imem_req_valid_o !== 1'b0 || insn_valid_o !== 1'b0 || retired_o !== 32'd5) begin
        fails++;
        $display("FAIL halt_hold cyc%0d: mis=%b rv=%b iv=%b ret=%0d (want 1 0 0 5)", i, misaligned_o, imem_req_valid_o, insn_valid_o, retired_o);
      end
    end
    imem_rsp_valid_i = 1'b0; commit_i = 1'b0; insn_ready_i = 1'b0; imem_req_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    reset = 1'b0; tick(); reset = 1'b1; tick();
    imem_req_ready_i = 1'b1; tick(); imem_req_ready_i = 1'b0;
    reset = 1'b0; #1;
    tests++;
    if (imem_req_valid_o !== 1'b0 || insn_valid_o !== 1'b0 || misaligned_o !== 1'b0 || retired_o !== 32'd0 ||
        imem_req_addr_o !== BASE || insn_o !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: rv=%b iv=%b mis=%b ret=%0d addr=%h insn=%h (want 0 0 0 0 %h 0)",
               imem_req_valid_o, insn_valid_o, misaligned_o, retired_o, imem_req_addr_o, insn_o, BASE);
    end
    @(negedge clk);
    imem_rsp_valid_i = 1'b1; imem_rsp_data_i = 32'h0BAD_0BAD; tick(); imem_rsp_valid_i = 1'b0;
    reset = 1'b1; tick();
    tests++;
    if (imem_req_valid_o !== 1'b1 || imem_req_addr_o !== BASE || insn_valid_o !== 1'b0 || insn_o !== 32'd0) begin
      fails++;
      $display("FAIL restart_after_reset: rv=%b addr=%h iv=%b insn=%h (want 1 %h 0 0)",
               imem_req_valid_o, imem_req_addr_o, insn_valid_o, insn_o, BASE);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_fetch_deliver();
    test_commit();
    test_wrap();
    test_misaligned();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch sequencer for the pd-series RISC-V core. It sits at the front of the datapath and consumes the `next_pc_o` value that writeback produces. It holds the architectural PC and issues one request at a time to instruction memory over a valid/ready request and a valid response. It delivers the fetched instruction to decode over a valid/ready handshake, then waits for writeback to commit the next PC before fetching again.

## Interface
Parameters:
- `DWIDTH`, 32, instruction/data width
- `AWIDTH`, 32, address width
- `BASEADDR`, 32'h0100_0000, PC loaded on reset

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = in reset)
- `imem_req_valid_o`  out  1  fetch request valid
- `imem_req_ready_i`  in  1  memory accepts request
- `imem_req_addr_o`  out  AWIDTH  fetch address (= current PC)
- `imem_rsp_valid_i`  in  1  response valid (single-cycle pulse)
- `imem_rsp_data_i`  in  DWIDTH  fetched instruction
- `insn_valid_o`  out  1  instruction available to decode
- `insn_ready_i`  in  1  decode accepts instruction
- `insn_o`  out  DWIDTH  held instruction
- `pc_o`  out  AWIDTH  PC of `insn_o`
- `commit_i`  in  1  writeback commit pulse
- `next_pc_i`  in  AWIDTH  next PC from writeback (pc+4 or branch target)
- `misaligned_o`  out  1  sticky: committed next PC not word-aligned
- `retired_o`  out  32  count of accepted commits

## Operation
- States: IDLE, REQ, WAIT, DELIVER, EXEC, HALT.
- IDLE is entered on reset. It moves to REQ on the first clock after reset deasserts.
- REQ: `imem_req_valid_o`=1 and `imem_req_addr_o`=PC.
  - Address and valid stay stable until `imem_req_ready_i`=1 is sampled.
  - On acceptance, go to WAIT.
- WAIT: on `imem_rsp_valid_i`=1, capture `imem_rsp_data_i` into the instruction register and go to DELIVER. Response pulses in any other state are ignored.
- DELIVER: `insn_valid_o`=1, with `insn_o` and `pc_o` held constant.
  - On `insn_ready_i`=1, go to EXEC.
- EXEC: wait for `commit_i`. On commit:
  - `retired_o` += 1 (wraps modulo 2^32).
  - If `next_pc_i[1:0]`≠0: set `misaligned_o`, leave PC unchanged, go to HALT.
  - Else PC ← `next_pc_i` and go to REQ.
- `commit_i` outside EXEC is ignored: no PC change and no count.
- HALT: no outputs asserted except `misaligned_o`. Only reset exits HALT.
- PC arithmetic is never performed here. `next_pc_i` is taken verbatim, so 0xFFFF_FFFC → 0x0000_0000 wrap comes from writeback and is legal (aligned).

## Timing
- Reset values:
  - `imem_req_valid_o`=0, `insn_valid_o`=0, `misaligned_o`=0, `retired_o`=0
  - `imem_req_addr_o`=`pc_o`=BASEADDR, `insn_o`=0
  - state=IDLE
- Reset deasserted at edge t0: REQ with valid=1 from t0+1.
- Minimum loop, commit accepted at edge t:
  - `imem_req_valid_o`=1 in cycle t+1.
  - If ready is sampled at t+1, WAIT from t+2.
  - A response at t+2 gives `insn_valid_o`=1 in cycle t+3.
- The response must arrive at least one cycle after request acceptance. A response in the acceptance cycle is ignored by design.
- Simultaneous `insn_ready_i` and `commit_i` while in DELIVER: only the handshake takes effect; the commit is ignored.
- Reset asserted mid-operation (any state) returns all state and outputs to reset values immediately (asynchronous). Any in-flight memory response is dropped because state is IDLE.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Structure
- Add the state enum `fetch_state_e` and the `BASEADDR` reset-PC constant to `constants.svh` so decode and the top level share them.
- Single module with no sub-module: state register, PC register, instruction register, sticky flag, retire counter.

## Test plan
- Reset/start: hold reset low 3 cycles, then release → all outputs at reset values during reset. One cycle later `imem_req_valid_o`=1 and addr=0x0100_0000.
- Request backpressure: `imem_req_ready_i`=0 for 3 cycles → valid and addr=0x0100_0000 stay stable. Ready on cycle 4 → WAIT.
- Fetch/deliver: response 0x0000_0013 → `insn_valid_o`=1, `insn_o`=0x0000_0013, `pc_o`=0x0100_0000. With `insn_ready_i` low 2 cycles, all three outputs hold.
- Commit path:
  - Commit `next_pc_i`=0x0100_0004 → next request addr=0x0100_0004 and `retired_o`=1.
  - Commit 0xDEAD_BEEC → request addr=0xDEAD_BEEC.
  - Commit pulsed during WAIT → ignored; count unchanged.
- Misaligned/wrap:
  - Commit 0xDEAD_BEEF → `misaligned_o`=1, no further requests. Responses and commits are ignored until reset.
  - Separately, commit 0x0000_0000 after PC 0xFFFF_FFFC → fetch at 0x0000_0000, no error.
- Reset mid-WAIT: assert reset, then a stale response arrives → outputs reset at once and the stale response is not delivered. Fetch restarts at 0x0100_0000.
